alu_out_stage: RTL and testbench
================================

# alu_out_stage

Registered output stage directly downstream of the 32-bit ALU. It captures the ALU result and zero flag together with the instruction's write-back tag and resolves BEQ/BNE branches from the flag. It presents the entry to the write-back stage over a valid/ready handshake, with a 2-entry skid buffer so that upstream `in_ready` never depends combinationally on `out_ready`.

## Interface
Parameters:
- `DATA_W`, 32: width of the ALU result and branch target.
- `REG_W`, 5: width of the destination register index.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream holds a valid ALU result this cycle.
- `in_ready`  out  1  stage can accept; registered.
- `alu_result`  in  DATA_W  ALU result.
- `alu_flag`  in  1  ALU zero flag; 1 when the result is 0.
- `in_rd`  in  REG_W  destination register.
- `in_reg_write`  in  1  instruction writes `in_rd`.
- `in_br_type`  in  2  branch type: 00 none, 01 BEQ, 10 BNE, 11 reserved (treated as none).
- `in_br_target`  in  DATA_W  branch target PC.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  write-back accepts the head entry.
- `out_result`  out  DATA_W  head entry result.
- `out_rd`  out  REG_W  head entry destination register.
- `out_reg_write`  out  1  head entry write-enable.
- `redirect`  out  1  one-cycle pulse: branch taken.
- `redirect_pc`  out  DATA_W  target PC; valid while `redirect`=1.
- `fwd_valid`, `fwd_rd`, `fwd_result`: present only with `ALU_OUT_FWD_EN`; see Configuration.

## Operation
- Accept occurs on a cycle where `in_valid & in_ready`. Release occurs on a cycle where `out_valid & out_ready`.
- Taken = (br_type==01 & alu_flag) | (br_type==10 & !alu_flag), evaluated at accept.
- Stored write-enable = `in_reg_write & (in_rd != 0) & (in_br_type ∉ {01,10})`. Branches never write.
- Every accepted entry is enqueued, including branches and non-writing entries, so downstream sees every instruction in order.
- State machine over occupancy:
  - EMPTY → ONE on accept.
  - ONE → EMPTY on release without accept.
  - ONE → TWO on accept without release.
  - ONE stays ONE on accept and release together.
  - TWO → ONE on release. No accept is possible in TWO.
- Entry order is FIFO. The head is the main register; the skid register refills the head on release from TWO.
- `in_ready` = next-state != TWO, registered.
- `out_*` are driven directly from the head register, with no combinational path from inputs.
- `redirect` is registered: asserted for exactly one cycle, the cycle after the accept of a taken branch. It is independent of `out_ready`.
- Reset (async, any time): state EMPTY; `in_ready`=1; `out_valid`=0; `out_result`=0; `out_rd`=0; `out_reg_write`=0; `redirect`=0; `redirect_pc`=0; `fwd_valid`=0. Any in-flight entries and any pending redirect are discarded.
- Payload registers do not need reset beyond the values above; the valid bits govern.

## Timing
- Latency: accept in cycle N → `out_valid`=1 in N+1.
- Throughput: 1 entry/cycle while `out_ready`=1.
- After `out_ready` deasserts with one entry held, one more entry is absorbed. `in_ready` drops in the following cycle.
- When `out_ready` returns in TWO, `in_ready` rises in the next cycle.
- Back-to-back taken branches produce `redirect` pulses in consecutive cycles.

## Configuration
- `ALU_OUT_FWD_EN` defined:
  - Forwarding ports exist and show the youngest valid entry: the skid entry if state TWO, else the head.
  - `fwd_valid` = that entry's stored write-enable.
  - `fwd_rd` and `fwd_result` are that entry's fields.
  - `fwd_valid`=0 when EMPTY.
- `ALU_OUT_FWD_EN` undefined: the three ports are absent and no forwarding logic is built.

## Structure
- Shared package `alu_pkg` holds:
  - `DATA_W` and `REG_W` defaults.
  - `br_type` encodings BR_NONE=00, BR_EQ=01, BR_NE=10.
  - The entry struct {result, rd, reg_write}.
  - Occupancy state encodings EMPTY/ONE/TWO.
- One sub-module `pipe_skid2`: a generic 2-entry skid buffer parameterised on payload width. `alu_out_stage` wraps it with the write-enable/branch logic and the redirect register.

## Test plan
- Reset mid-traffic: hold `out_ready`=0, accept 2 entries, pulse `rst_n` low → `out_valid`=0, `in_ready`=1, `redirect`=0 immediately (asynchronously).
- Streaming: 8 entries with results 1..8, `out_ready`=1 → outputs 1..8 in order, one per cycle, first one cycle after the first accept.
- Backpressure: `out_ready`=0 after the first accept → second entry accepted, `in_ready`=0 from the next cycle. Release → both entries emerge in order, and `in_ready`=1 one cycle after the first release.
- Branch: BEQ with flag=1, target 0x40 → `redirect`=1 with `redirect_pc`=0x40 for exactly one cycle after accept, and `out_reg_write`=0. BNE with flag=1 → no redirect.
- x0 suppression: `in_reg_write`=1, `in_rd`=0, result 0xDEADBEEF → `out_reg_write`=0, result still output.
- `ALU_OUT_FWD_EN`: state TWO with head rd=3 and skid rd=7 → `fwd_rd`=7 and `fwd_result` = the skid result.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU output stage: default widths, branch-type
// encodings, the buffered entry layout and the skid-buffer occupancy states.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_EQ   = 2'b01;
  localparam logic [1:0] BR_NE   = 2'b10;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [REG_W-1:0]  rd;
    logic              reg_write;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_t;

endpackage

// File: rtl/alu_out_stage_if.sv
// Bundle of the ALU-side input, write-back-side output and redirect signals.
// Forwarding signals exist only when ALU_OUT_FWD_EN is defined.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high; valid and its payload hold until that edge, ready may change freely.
interface alu_out_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] alu_result;
  logic              alu_flag;
  logic [REG_W-1:0]  in_rd;
  logic              in_reg_write;
  logic [1:0]        in_br_type;
  logic [DATA_W-1:0] in_br_target;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [REG_W-1:0]  out_rd;
  logic              out_reg_write;

  logic              redirect;
  logic [DATA_W-1:0] redirect_pc;

`ifdef ALU_OUT_FWD_EN
  logic              fwd_valid;
  logic [REG_W-1:0]  fwd_rd;
  logic [DATA_W-1:0] fwd_result;

  modport master (
    output in_valid, alu_result, alu_flag, in_rd, in_reg_write, in_br_type, in_br_target,
    output out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_reg_write,
    input  redirect, redirect_pc, fwd_valid, fwd_rd, fwd_result
  );

  modport slave (
    input  in_valid, alu_result, alu_flag, in_rd, in_reg_write, in_br_type, in_br_target,
    input  out_ready,
    output in_ready, out_valid, out_result, out_rd, out_reg_write,
    output redirect, redirect_pc, fwd_valid, fwd_rd, fwd_result
  );
`else
  modport master (
    output in_valid, alu_result, alu_flag, in_rd, in_reg_write, in_br_type, in_br_target,
    output out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_reg_write,
    input  redirect, redirect_pc
  );

  modport slave (
    input  in_valid, alu_result, alu_flag, in_rd, in_reg_write, in_br_type, in_br_target,
    input  out_ready,
    output in_ready, out_valid, out_result, out_rd, out_reg_write,
    output redirect, redirect_pc
  );
`endif

endinterface

// File: rtl/pipe_skid2.sv
// Generic 2-entry skid buffer. in_ready is registered, so the upstream side
// never sees a combinational path from out_ready.
module pipe_skid2
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [W-1:0] skid_data,
  output occ_state_t   state
);

  occ_state_t   state_q, state_d;
  logic         in_ready_q;
  logic [W-1:0] head_q, skid_q;
  logic         accept, rel;
  logic         load_head, load_skid, head_from_skid;

  assign accept    = in_valid & in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign rel       = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    load_head      = 1'b0;
    load_skid      = 1'b0;
    head_from_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d   = ONE;
          load_head = 1'b1;
        end
      end
      ONE: begin
        if (accept && !rel) begin
          state_d   = TWO;
          load_skid = 1'b1;
        end else if (!accept && rel) begin
          state_d = EMPTY;
        end else if (accept && rel) begin
          load_head = 1'b1;
        end
      end
      TWO: begin
        // in_ready is low here, so only a release can happen
        if (rel) begin
          state_d        = ONE;
          head_from_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      head_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
      if (load_head)           head_q <= in_data;
      else if (head_from_skid) head_q <= skid_q;
    end
  end

  // The skid payload is only meaningful in TWO, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load_skid) skid_q <= in_data;
  end

  assign in_ready  = in_ready_q;
  assign out_data  = head_q;
  assign skid_data = skid_q;
  assign state     = state_q;

endmodule

// File: rtl/alu_out_stage.sv
// Registered output stage after the ALU: buffers results for write-back and
// resolves BEQ/BNE into a one-cycle redirect. ALU_OUT_FWD_EN adds forwarding.
module alu_out_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int REG_W  = alu_pkg::REG_W
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_out_stage_if.slave bus,
  output occ_state_t dbg_state
);

  localparam int ENTRY_W = DATA_W + REG_W + 1;

  logic               is_branch, taken, wr_en, accept;
  logic [ENTRY_W-1:0] in_entry, head_entry, skid_entry;
  logic               redirect_q;
  logic [DATA_W-1:0]  redirect_pc_q;

  assign is_branch = (bus.in_br_type == BR_EQ) || (bus.in_br_type == BR_NE);
  assign taken     = ((bus.in_br_type == BR_EQ) &&  bus.alu_flag) ||
                     ((bus.in_br_type == BR_NE) && !bus.alu_flag);
  // Branches and x0 writes are still enqueued, just never write back.
  assign wr_en     = bus.in_reg_write && (bus.in_rd != '0) && !is_branch;
  assign in_entry  = {bus.alu_result, bus.in_rd, wr_en};
  assign accept    = bus.in_valid & bus.in_ready;

  pipe_skid2 #(.W(ENTRY_W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_entry),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (head_entry),
    .skid_data (skid_entry),
    .state     (dbg_state)
  );

  assign bus.out_result    = head_entry[ENTRY_W-1 -: DATA_W];
  assign bus.out_rd        = head_entry[REG_W:1];
  assign bus.out_reg_write = head_entry[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      redirect_q <= accept & taken;
      if (accept && taken) redirect_pc_q <= bus.in_br_target;
    end
  end

  assign bus.redirect    = redirect_q;
  assign bus.redirect_pc = redirect_pc_q;

`ifdef ALU_OUT_FWD_EN
  logic [ENTRY_W-1:0] young_entry;

  // The youngest buffered entry is the one a dependent instruction needs.
  assign young_entry    = (dbg_state == TWO) ? skid_entry : head_entry;
  assign bus.fwd_valid  = (dbg_state != EMPTY) & young_entry[0];
  assign bus.fwd_rd     = young_entry[REG_W:1];
  assign bus.fwd_result = young_entry[ENTRY_W-1 -: DATA_W];
`else
  logic unused_skid;
  assign unused_skid = ^skid_entry;
`endif

endmodule

// File: tb/tb_alu_out_stage.sv
// Bench for alu_out_stage: reference occupancy/redirect model plus an entry
// scoreboard, directed cases and randomised backpressure traffic.
module tb_alu_out_stage;
  import alu_pkg::*;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int EW = DW + RW + 1;

  logic       clk;
  logic       rst_n;
  occ_state_t dbg_state;

  alu_out_stage_if #(.DATA_W(DW), .REG_W(RW)) bus ();

  alu_out_stage #(.DATA_W(DW), .REG_W(RW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // scoreboard and reference model, evaluated mid-cycle
  logic [EW-1:0] exp_q[$];
  int            m_occ      = 0;
  logic          m_in_ready = 1'b1;
  logic          m_redir    = 1'b0;
  logic [DW-1:0] m_redir_pc = '0;

  always @(negedge clk) begin
    logic          acc, rel, m_taken, m_br, m_wr;
    logic [EW-1:0] e;
    if (!rst_n) begin
      exp_q.delete();
      m_occ      = 0;
      m_in_ready = 1'b1;
      m_redir    = 1'b0;
    end else begin
      check("in_ready", bus.in_ready, m_in_ready);
      check("out_valid", bus.out_valid, m_occ != 0);
      check("redirect", bus.redirect, m_redir);
      if (m_redir) check("redirect_pc", bus.redirect_pc, m_redir_pc);
`ifdef ALU_OUT_FWD_EN
      if (m_occ == 0) check("fwd_valid_empty", bus.fwd_valid, 1'b0);
      else if (exp_q.size() > 0)
        check("fwd_entry", {bus.fwd_result, bus.fwd_rd, bus.fwd_valid}, exp_q[$]);
`endif
      rel = bus.out_valid & bus.out_ready;
      if (rel) begin
        if (exp_q.size() == 0) check("unexpected_out", 1'b1, 1'b0);
        else begin
          e = exp_q.pop_front();
          check("out_entry", {bus.out_result, bus.out_rd, bus.out_reg_write}, e);
        end
      end
      acc     = bus.in_valid & bus.in_ready;
      m_br    = (bus.in_br_type == 2'b01) || (bus.in_br_type == 2'b10);
      m_taken = ((bus.in_br_type == 2'b01) && bus.alu_flag) ||
                ((bus.in_br_type == 2'b10) && !bus.alu_flag);
      m_wr    = bus.in_reg_write && (bus.in_rd != 0) && !m_br;
      if (acc) exp_q.push_back({bus.alu_result, bus.in_rd, m_wr});
      m_redir = acc && m_taken;
      if (m_redir) m_redir_pc = bus.in_br_target;
      m_occ      = m_occ + (acc ? 1 : 0) - (rel ? 1 : 0);
      m_in_ready = (m_occ != 2);
    end
  end

  // driver: call and return at 1 time unit after a rising edge
  task automatic send(input logic [DW-1:0] res, input logic [RW-1:0] rd, input logic rw,
                      input logic [1:0] br, input logic flag, input logic [DW-1:0] tgt);
    int n;
    bus.in_valid     = 1'b1;
    bus.alu_result   = res;
    bus.in_rd        = rd;
    bus.in_reg_write = rw;
    bus.in_br_type   = br;
    bus.alu_flag     = flag;
    bus.in_br_target = tgt;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("send_timeout", 1'b1, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    bus.in_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  bit rand_done;

  initial begin
    rst_n            = 1'b0;
    bus.in_valid     = 1'b0;
    bus.alu_result   = '0;
    bus.alu_flag     = 1'b0;
    bus.in_rd        = '0;
    bus.in_reg_write = 1'b0;
    bus.in_br_type   = 2'b00;
    bus.in_br_target = '0;
    bus.out_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;

    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_result", bus.out_result, 32'h0);
    check("rst_out_rd", bus.out_rd, 5'd0);
    check("rst_out_reg_write", bus.out_reg_write, 1'b0);
    check("rst_redirect", bus.redirect, 1'b0);
    check("rst_redirect_pc", bus.redirect_pc, 32'h0);
    check("rst_state", dbg_state, EMPTY);
`ifdef ALU_OUT_FWD_EN
    check("rst_fwd_valid", bus.fwd_valid, 1'b0);
`endif
    @(posedge clk);
    #1;

    // streaming 1..8 at full rate
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send(i, 5'(i), 1'b1, 2'b00, 1'b0, '0);
    idle(3);

    // backpressure: two entries absorbed, then released in order
    bus.out_ready = 1'b0;
    send(32'h100, 5'd3, 1'b1, 2'b00, 1'b0, '0);
    send(32'h200, 5'd7, 1'b1, 2'b00, 1'b0, '0);
    bus.in_valid = 1'b0;
    check("bp_in_ready_low", bus.in_ready, 1'b0);
    check("bp_state_two", dbg_state, TWO);
`ifdef ALU_OUT_FWD_EN
    check("fwd_rd_skid", bus.fwd_rd, 5'd7);
    check("fwd_result_skid", bus.fwd_result, 32'h200);
    check("fwd_valid_skid", bus.fwd_valid, 1'b1);
`endif
    idle(2);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_in_ready_back", bus.in_ready, 1'b1);
    idle(3);

    // branches
    send(32'h0, 5'd4, 1'b1, 2'b01, 1'b1, 32'h40);
    bus.in_valid = 1'b0;
    check("beq_redirect", bus.redirect, 1'b1);
    check("beq_redirect_pc", bus.redirect_pc, 32'h40);
    check("beq_no_write", bus.out_reg_write, 1'b0);
    @(posedge clk);
    #1;
    check("beq_redirect_pulse", bus.redirect, 1'b0);
    send(32'h0, 5'd4, 1'b0, 2'b10, 1'b1, 32'h80);
    bus.in_valid = 1'b0;
    check("bne_not_taken", bus.redirect, 1'b0);
    idle(2);
    send(32'h5, 5'd1, 1'b0, 2'b10, 1'b0, 32'h100);
    send(32'h0, 5'd1, 1'b0, 2'b01, 1'b1, 32'h200);
    send(32'h0, 5'd9, 1'b1, 2'b11, 1'b1, 32'h300);
    idle(3);

    // x0 suppression
    send(32'hDEADBEEF, 5'd0, 1'b1, 2'b00, 1'b0, '0);
    bus.in_valid = 1'b0;
    check("x0_result", bus.out_result, 32'hDEADBEEF);
    check("x0_no_write", bus.out_reg_write, 1'b0);
    idle(3);

    // randomised traffic against random backpressure
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          send($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
          if ($urandom_range(0, 3) == 0) idle(1);
        end
        bus.in_valid = 1'b0;
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    idle(5);
    check("drain_empty", exp_q.size(), 0);

    // reset mid-traffic, with a redirect pending
    bus.out_ready = 1'b0;
    send(32'h11, 5'd2, 1'b1, 2'b00, 1'b0, '0);
    send(32'h0, 5'd2, 1'b0, 2'b01, 1'b1, 32'h500);
    bus.in_valid = 1'b0;
    check("pre_rst_redirect", bus.redirect, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", bus.out_valid, 1'b0);
    check("async_rst_in_ready", bus.in_ready, 1'b1);
    check("async_rst_redirect", bus.redirect, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(32'h77, 5'd6, 1'b1, 2'b00, 1'b0, '0);
    idle(4);
    check("final_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
